// File: rtl/blake_msg_loader_if.sv
// Message stream and block handoff bundle for the BLAKE-512 loader.
// master drives words and accept strobe; slave is the loader.
interface blake_msg_loader_if #(
  parameter int NWORDS = 10
);
  logic [63:0]          din;
  logic                 din_valid;
  logic                 din_ready;
  logic [31:0]          sweep_cnt;
  logic                 init_round;
  logic [64*NWORDS-1:0] din_swapped;
  logic                 blk_valid;

  modport master (
    output din, din_valid, sweep_cnt, init_round,
    input  din_ready, din_swapped, blk_valid
  );

  modport slave (
    input  din, din_valid, sweep_cnt, init_round,
    output din_ready, din_swapped, blk_valid
  );
endinterface

// File: rtl/blake_msg_loader.sv
// BLAKE-512 header loader: collects ten byte-swapped words into a
// 640-bit block and optionally sweeps the nonce across accepts.
module blake_msg_loader #(
  parameter int NWORDS  = 10,
  parameter int SWAP_EN = 1
) (
  input logic clk,
  input logic rst,
  input logic flush,
  blake_msg_loader_if.slave bus
);
  localparam int BW  = 64 * NWORDS;
  localparam int WCW = $clog2(NWORDS);

  typedef enum logic {
    S_COLLECT,
    S_FULL
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [31:0]    remain_q, remain_d;
  logic [BW-1:0]  blk_q, blk_d;
  logic [63:0]    word_in;

  // header arrives big-endian; the core wants little-endian words
  always_comb begin
    word_in = bus.din;
    if (SWAP_EN != 0) begin
      for (int j = 0; j < 8; j++) begin
        word_in[8*j +: 8] = bus.din[8*(7-j) +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    remain_d = remain_q;
    blk_d    = blk_q;
    if (flush) begin
      state_d  = S_COLLECT;
      wcnt_d   = '0;
      remain_d = '0;
      blk_d    = '0;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          if (bus.din_valid) begin
            for (int k = 0; k < NWORDS; k++) begin
              if (wcnt_q == WCW'(k)) begin
                blk_d[BW-64*(k+1) +: 64] = word_in;
              end
            end
            if (wcnt_q == WCW'(NWORDS-1)) begin
              wcnt_d   = '0;
              remain_d = bus.sweep_cnt;
              state_d  = S_FULL;
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
        S_FULL: begin
          if (bus.init_round) begin
            if (remain_q != '0) begin
              blk_d[31:0] = blk_q[31:0] + 32'd1;
              remain_d    = remain_q - 1'b1;
            end else begin
              state_d = S_COLLECT;
            end
          end
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_COLLECT;
      wcnt_q   <= '0;
      remain_q <= '0;
      blk_q    <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      remain_q <= remain_d;
      blk_q    <= blk_d;
    end
  end

  assign bus.din_ready   = (state_q == S_COLLECT);
  assign bus.blk_valid   = (state_q == S_FULL);
  assign bus.din_swapped = blk_q;
endmodule

// File: tb/tb_blake_msg_loader.sv
// Bench for blake_msg_loader: block-level model checked every
// cycle plus literal expectations for the directed scenarios.
module tb_blake_msg_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  blake_msg_loader_if #(.NWORDS(10)) bus();

  blake_msg_loader #(
    .NWORDS(10),
    .SWAP_EN(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit           m_full;
  int           m_cnt;
  logic [31:0]  m_rem;
  logic [639:0] m_blk;

  logic [63:0] w1[10];
  logic [63:0] w2[10];
  logic [31:0] exp_n[4];

  function automatic logic [63:0] bswap(input logic [63:0] w);
    return {<<8{w}};
  endfunction

  function automatic logic [639:0] build(input logic [63:0] w[10]);
    logic [639:0] b;
    b = '0;
    for (int k = 0; k < 10; k++) b[64*(9-k) +: 64] = bswap(w[k]);
    return b;
  endfunction

  task automatic chk(input string nm,
                     input logic [639:0] act,
                     input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // model: block = list of swapped words, plus sweep counter
  initial begin
    m_full = 0;
    m_cnt  = 0;
    m_rem  = '0;
    m_blk  = '0;
    forever begin
      @(posedge clk);
      if (rst || flush) begin
        m_full = 0;
        m_cnt  = 0;
        m_rem  = '0;
        m_blk  = '0;
      end else if (!m_full) begin
        if (bus.din_valid) begin
          m_blk[64*(9-m_cnt) +: 64] = bswap(bus.din);
          m_cnt++;
          if (m_cnt == 10) begin
            m_cnt  = 0;
            m_full = 1;
            m_rem  = bus.sweep_cnt;
          end
        end
      end else if (bus.init_round) begin
        if (m_rem != 0) begin
          m_blk[31:0] = m_blk[31:0] + 32'd1;
          m_rem = m_rem - 32'd1;
        end else begin
          m_full = 0;
        end
      end
      #1;
      chk("din_ready", 640'(bus.din_ready), 640'(!m_full));
      chk("blk_valid", 640'(bus.blk_valid), 640'(m_full));
      chk("din_swapped", bus.din_swapped, m_blk);
    end
  end

  task automatic load(input logic [63:0] w[10], input int n,
                      input logic [31:0] sw, input bit rnd);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.din = w[i];
      bus.sweep_cnt = (i == 9) ? sw : 32'h5A5A0000 + 32'(i);
      bus.din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.din_valid && bus.din_ready) i++;
    end
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL load_timeout act=%0d exp=%0d", i, n);
    end
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic accept();
    bus.init_round = 1'b1;
    @(negedge clk);
    bus.init_round = 1'b0;
  endtask

  initial begin
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.sweep_cnt = '0;
    bus.init_round = 1'b0;
    for (int k = 0; k < 10; k++) begin
      w1[k] = 64'h0001020304050607 + 64'h0808080808080808 * k;
      w2[k] = w1[k] ^ 64'hA5C3_0F96_1234_8765;
    end
    w2[9] = 64'hFEFFFFFF_11223344;
    exp_n[0] = 32'hFFFFFFFE;
    exp_n[1] = 32'hFFFFFFFF;
    exp_n[2] = 32'h00000000;
    exp_n[3] = 32'h00000001;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 640'(bus.din_ready), 640'd1);
    chk("rst_valid", 640'(bus.blk_valid), 640'd0);
    chk("rst_blk", bus.din_swapped, 640'd0);

    // full-rate load, no sweep
    load(w1, 10, 32'd0, 1'b0);
    chk("t1_valid", 640'(bus.blk_valid), 640'd1);
    chk("t1_ready", 640'(bus.din_ready), 640'd0);
    chk("t1_slot0", 640'(bus.din_swapped[639:576]),
        640'(64'h0706050403020100));
    chk("t1_model0", 640'(m_blk[639:576]),
        640'(64'h0706050403020100));
    chk("t1_slot9", 640'(bus.din_swapped[63:0]),
        640'(64'h4F4E4D4C4B4A4948));
    accept();
    chk("t1_ready_after", 640'(bus.din_ready), 640'd1);
    chk("t1_hold", 640'(bus.din_swapped[639:576]),
        640'(64'h0706050403020100));

    // nonce sweep with wrap
    load(w2, 10, 32'd3, 1'b0);
    chk("t2_low", 640'(bus.din_swapped[63:0]),
        640'(64'h44332211_FFFFFFFE));
    bus.init_round = 1'b1;
    chk("t2_n0", 640'(bus.din_swapped[31:0]), 640'(exp_n[0]));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("t2_nonce", 640'(bus.din_swapped[31:0]), 640'(exp_n[i]));
      chk("t2_valid", 640'(bus.blk_valid), 640'd1);
    end
    @(negedge clk);
    bus.init_round = 1'b0;
    chk("t2_done_valid", 640'(bus.blk_valid), 640'd0);
    chk("t2_done_ready", 640'(bus.din_ready), 640'd1);
    chk("t2_done_nonce", 640'(bus.din_swapped[31:0]), 640'd1);

    // gapped load matches full-rate block
    load(w1, 10, 32'd0, 1'b1);
    chk("t3_block", bus.din_swapped, build(w1));
    accept();

    // flush after word 6 with a word on offer
    load(w2, 7, 32'd0, 1'b0);
    bus.din = w2[7];
    bus.din_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.din_valid = 1'b0;
    chk("t4_blk", bus.din_swapped, 640'd0);
    chk("t4_ready", 640'(bus.din_ready), 640'd1);
    load(w1, 10, 32'd0, 1'b0);
    chk("t4_block", bus.din_swapped, build(w1));
    chk("t4_valid", 640'(bus.blk_valid), 640'd1);
    accept();

    // init_round in COLLECT, din_valid in FULL
    bus.init_round = 1'b1;
    repeat (2) @(negedge clk);
    bus.init_round = 1'b0;
    chk("t5_idle_blk", bus.din_swapped, build(w1));
    chk("t5_idle_ready", 640'(bus.din_ready), 640'd1);
    load(w2, 10, 32'd1, 1'b0);
    bus.din = 64'hDEADBEEF_CAFEF00D;
    bus.din_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.din_valid = 1'b0;
    chk("t5_stall_blk", bus.din_swapped, build(w2));
    chk("t5_stall_valid", 640'(bus.blk_valid), 640'd1);
    accept();
    chk("t5_nonce", 640'(bus.din_swapped[31:0]), 640'(32'hFFFFFFFF));
    accept();
    chk("t5_end", 640'(bus.blk_valid), 640'd0);

    // async reset mid-sweep
    load(w1, 10, 32'd7, 1'b0);
    bus.init_round = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_valid", 640'(bus.blk_valid), 640'd0);
    chk("t6_ready", 640'(bus.din_ready), 640'd1);
    chk("t6_blk", bus.din_swapped, 640'd0);
    bus.init_round = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_post", bus.din_swapped, 640'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
